load_store_unit: RTL and testbench

- Memory-side responder for the pipeline's memory stage. It accepts one load/store request per transaction (store flag from the control logic's memory write enable, address from the ALU, store data from rs2, funct3 from the instruction).
- It checks alignment, drives a word-aligned req/ack data bus with byte enables, and returns sign/zero-extended load data to writeback.
- It holds the pipeline busy while a transaction is outstanding.

---
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage responder. Takes one load/store per transaction, checks
//   funct3 legality and alignment, runs a single req/ack transfer on a
//   word-aligned bus with byte enables, and returns formatted load data.
//
// Ports
//   clk, rst_n                 clock / async active-low reset
//   req_valid_i/req_ready_o    request handshake (ready only in IDLE)
//   req_we_i, req_funct3_i     store flag, width/sign select
//   req_addr_i, req_wdata_i    byte address, LSB-aligned store data
//   rsp_valid_o                one-cycle completion pulse
//   rsp_rdata_o, rsp_err_o     formatted load data, error flag
//   busy_o                     pipeline stall
//   bus_req_o .. bus_wdata_o   bus request side (valid while bus_req_o)
//   bus_ack_i, bus_rdata_i     completion and read word
//   bus_err_i                  bus error, also completes the transfer
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    localparam int NUM_LANES = 4;
    localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Last BUS cycle index before abort; counter holds cycles already spent.
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t             state_q, state_d;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;

    logic               req_bad;
    logic               timeout_hit;
    logic               in_bus;
    logic [3:0]         be;
    logic [31:0]        wdata_rep;
    logic [31:0]        rd_shift;
    logic [31:0]        rd_fmt;

    // Legality of the incoming request (checked only at accept).
    always_comb begin
        logic illegal;
        logic misal;
        if (req_we_i)
            illegal = (req_funct3_i >= 3'b011);
        else
            illegal = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                      (req_funct3_i == 3'b111);
        misal = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        req_bad = illegal || misal;
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
    assign in_bus      = (state_q == BUS);

    // Per-byte-lane enables and replicated store data from the latched request.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        always_comb begin
            unique case (f3_q[1:0])
                2'b00: begin
                    be[l]              = (addr_q[1:0] == 2'(l));
                    wdata_rep[l*8 +: 8] = wdata_q[7:0];
                end
                2'b01: begin
                    be[l]              = (addr_q[1] == 1'(l / 2));
                    wdata_rep[l*8 +: 8] = wdata_q[(l % 2)*8 +: 8];
                end
                default: begin
                    be[l]              = 1'b1;
                    wdata_rep[l*8 +: 8] = wdata_q[l*8 +: 8];
                end
            endcase
        end
    end

    // Load formatting: shift the addressed lane down, then extend.
    assign rd_shift = bus_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        unique case (f3_q)
            3'b000:  rd_fmt = {{24{rd_shift[7]}},  rd_shift[7:0]};
            3'b001:  rd_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  rd_fmt = {24'h0, rd_shift[7:0]};
            3'b101:  rd_fmt = {16'h0, rd_shift[15:0]};
            default: rd_fmt = bus_rdata_i;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state. Error takes priority over ack in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid_i) state_d = req_bad ? DONE : BUS;
            BUS:  if (bus_err_i || bus_ack_i || timeout_hit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, BUS cycle counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            cnt_q       <= '0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (req_valid_i) begin
                    we_q    <= req_we_i;
                    f3_q    <= req_funct3_i;
                    addr_q  <= req_addr_i;
                    wdata_q <= req_wdata_i;
                    cnt_q   <= '0;
                    if (req_bad) begin
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b1;
                    end
                end
                BUS: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus_err_i || (!bus_ack_i && timeout_hit)) begin
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b1;
                    end else if (bus_ack_i) begin
                        rsp_rdata_q <= we_q ? 32'h0 : rd_fmt;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE) || req_valid_i;
    assign rsp_valid_o = (state_q == DONE);
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = (state_q == DONE) && rsp_err_q;

    // Bus side is quiet outside BUS so reset and idle drive all zeros.
    assign bus_req_o   = in_bus;
    assign bus_we_o    = in_bus && we_q;
    assign bus_addr_o  = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_be_o    = in_bus ? be : 4'b0000;
    assign bus_wdata_o = in_bus ? wdata_rep : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, t_req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_f3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        bus_ack = 1'b0, bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    logic        req_ready, rsp_valid, rsp_err, busy, bus_req, bus_we;
    logic [31:0] rsp_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    logic        t_req_ready, t_rsp_valid, t_rsp_err, t_busy, t_bus_req, t_bus_we;
    logic [31:0] t_rsp_rdata, t_bus_addr, t_bus_wdata;
    logic [3:0]  t_bus_be;

    int checks = 0;
    int failures = 0;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_funct3_i(req_f3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .busy_o(busy),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
        .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata), .bus_err_i(bus_err)
    );

    // Short-timeout instance; its bus never answers.
    load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(t_req_valid), .req_ready_o(t_req_ready),
        .req_we_i(req_we), .req_funct3_i(req_f3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(t_rsp_valid), .rsp_rdata_o(t_rsp_rdata), .rsp_err_o(t_rsp_err),
        .busy_o(t_busy),
        .bus_req_o(t_bus_req), .bus_we_o(t_bus_we), .bus_addr_o(t_bus_addr),
        .bus_be_o(t_bus_be), .bus_wdata_o(t_bus_wdata),
        .bus_ack_i(1'b0), .bus_rdata_i(32'h0), .bus_err_i(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {31'h0, rsp_valid}, 32'h0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
            end
        end
    end

    task automatic drive_req(input bit to_t, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        req_we = we; req_f3 = f3; req_addr = a; req_wdata = d;
        if (to_t) t_req_valid = 1'b1; else req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; t_req_valid = 1'b0;
    endtask

    // Called at a negedge inside BUS: ack (and optionally err) for one cycle.
    task automatic reply(input logic [31:0] rd, input logic err);
        bus_ack = 1'b1; bus_err = err; bus_rdata = rd;
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_err = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_rsp", {31'h0, rsp_valid}, 32'h0);
        check("rst_be", {28'h0, bus_be}, 32'h0);
        rst_n = 1'b1;

        // LB 0x1003, sign-extend top byte
        exp_q.push_back('{32'hFFFF_FF80, 1'b0});
        drive_req(0, 1'b0, 3'b000, 32'h1003, 32'h0);
        @(negedge clk);
        check("lb_req", {31'h0, bus_req}, 32'h1);
        check("lb_addr", bus_addr, 32'h1000);
        check("lb_be", {28'h0, bus_be}, 32'h8);
        check("lb_we", {31'h0, bus_we}, 32'h0);
        check("lb_ready", {31'h0, req_ready}, 32'h0);
        reply(32'h80FF_1234, 1'b0);
        wait_rsp("lb_done");

        // SH 0x2002
        exp_q.push_back('{32'h0, 1'b0});
        drive_req(0, 1'b1, 3'b001, 32'h2002, 32'h0000_ABCD);
        @(negedge clk);
        check("sh_we", {31'h0, bus_we}, 32'h1);
        check("sh_be", {28'h0, bus_be}, 32'hC);
        check("sh_wdata", bus_wdata, 32'hABCD_ABCD);
        reply(32'h5555_5555, 1'b0);
        wait_rsp("sh_done");

        // Misaligned LW: error next cycle, no bus cycle
        exp_q.push_back('{32'h0, 1'b1});
        drive_req(0, 1'b0, 3'b010, 32'h3001, 32'h0);
        @(negedge clk);
        check("mis_no_req", {31'h0, bus_req}, 32'h0);
        check("mis_rsp_now", {31'h0, rsp_valid}, 32'h1);
        wait_rsp("mis_done");

        // Illegal store funct3
        exp_q.push_back('{32'h0, 1'b1});
        drive_req(0, 1'b1, 3'b011, 32'h3000, 32'h0);
        @(negedge clk);
        check("ill_no_req", {31'h0, bus_req}, 32'h0);
        wait_rsp("ill_done");

        // LHU 0x3002
        exp_q.push_back('{32'h0000_8001, 1'b0});
        drive_req(0, 1'b0, 3'b101, 32'h3002, 32'h0);
        @(negedge clk);
        check("lhu_be", {28'h0, bus_be}, 32'hC);
        reply(32'h8001_0000, 1'b0);
        wait_rsp("lhu_done");

        // LH 0x1000 sign-extends bit 15
        exp_q.push_back('{32'hFFFF_9234, 1'b0});
        drive_req(0, 1'b0, 3'b001, 32'h1000, 32'h0);
        @(negedge clk);
        reply(32'h7777_9234, 1'b0);
        wait_rsp("lh_done");

        // Ack and err together: err wins
        exp_q.push_back('{32'h0, 1'b1});
        drive_req(0, 1'b0, 3'b010, 32'h7000, 32'h0);
        @(negedge clk);
        reply(32'h1234_5678, 1'b1);
        wait_rsp("ackerr_done");

        // Timeout on the 4-cycle instance
        begin
            int req_cyc = 0;
            bit saw = 1'b0;
            logic s_err = 1'b0;
            logic [31:0] s_rd = 32'hX;
            drive_req(1, 1'b0, 3'b010, 32'h8000, 32'h0);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (t_bus_req) req_cyc++;
                if (t_rsp_valid) begin saw = 1'b1; s_err = t_rsp_err; s_rd = t_rsp_rdata; end
            end
            check("to_req_cycles", req_cyc, 4);
            check("to_rsp_seen", {31'h0, saw}, 32'h1);
            check("to_rsp_err", {31'h0, s_err}, 32'h1);
            check("to_rsp_rdata", s_rd, 32'h0);
            check("to_ready", {31'h0, t_req_ready}, 32'h1);
        end

        // Delayed ack, second request held until ready
        exp_q.push_back('{32'h0, 1'b0});
        exp_q.push_back('{32'h1122_3344, 1'b0});
        drive_req(0, 1'b1, 3'b000, 32'h5005, 32'h0000_00AB);
        req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h4000; req_wdata = 32'h0;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("dly_req", {31'h0, bus_req}, 32'h1);
            check("dly_addr", bus_addr, 32'h5004);
            check("dly_be", {28'h0, bus_be}, 32'h2);
            check("dly_wdata", bus_wdata, 32'hABAB_ABAB);
            check("dly_busy_ready", {30'h0, busy, req_ready}, 32'h2);
        end
        reply(32'h0, 1'b0);
        begin
            bit got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (req_ready) got = 1'b1;
            end
            check("dly_ready_back", {31'h0, got}, 32'h1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("dly2_addr", bus_addr, 32'h4000);
        check("dly2_be", {28'h0, bus_be}, 32'hF);
        reply(32'h1122_3344, 1'b0);
        wait_rsp("dly_done");

        // Reset in BUS: transaction lost, then a normal LW
        drive_req(0, 1'b0, 3'b010, 32'h6100, 32'h0);
        @(negedge clk);
        check("rb_req", {31'h0, bus_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rb_req_drop", {31'h0, bus_req}, 32'h0);
        check("rb_ready", {31'h0, req_ready}, 32'h1);
        check("rb_rsp", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{32'hDEAD_BEEF, 1'b0});
        drive_req(0, 1'b0, 3'b010, 32'h6000, 32'h0);
        @(negedge clk);
        check("rb2_addr", bus_addr, 32'h6000);
        reply(32'hDEAD_BEEF, 1'b0);
        wait_rsp("rb2_done");

        repeat (3) @(negedge clk);
        check("final_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
